// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NREQ byte producers
// Optional packet lock (lock port) enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              tx_load,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              arb_busy,
  output logic              err_timeout
`ifdef UART_ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0]   lock
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr, ptr_nx;
  logic [IW-1:0]   win, win_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            hold, hold_nx;
  logic [NREQ-1:0] gnt_nx;
  logic            tx_load_nx;
  logic [7:0]      tx_data_nx;
  logic            err_nx;
  logic            lock_w;
  logic            locked_now;
  logic [IW-1:0]   base;
  logic            found;
  logic [IW-1:0]   pick;
  logic            grant_ok;
  logic [IW-1:0]   pick_f;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
    if (x == IW'(NREQ - 1)) return '0;
    return x + IW'(1);
  endfunction

`ifdef UART_ARB_LOCK_EN
  assign lock_w = lock[win];
`else
  assign lock_w = 1'b0;
`endif

  // hold marks that the last byte left with its lock set; while that lock stays up only win may be served
  assign locked_now = hold && lock_w;
  assign base       = hold ? next_idx(win) : ptr;

  always_comb begin
    logic [IW-1:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = base;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = next_idx(idx);
    end
  end

  assign grant_ok = locked_now ? req[win] : found;
  assign pick_f   = locked_now ? win : pick;

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    win_nx     = win;
    cnt_nx     = cnt;
    hold_nx    = hold;
    gnt_nx     = '0;
    tx_load_nx = 1'b0;
    tx_data_nx = tx_data;
    err_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy && grant_ok) begin
          win_nx         = pick_f;
          tx_data_nx     = req_data[{pick_f, 3'b000} +: 8];
          gnt_nx[pick_f] = 1'b1;
          hold_nx        = 1'b0;
          state_nx       = LOAD;
        end
      end
      LOAD: begin
        tx_load_nx = 1'b1;
        cnt_nx     = '0;
        state_nx   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        cnt_nx = cnt + CW'(1);
        if (tx_busy) begin
          state_nx = WAIT_DONE;
        end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
          // the byte is dropped; a lock never survives a dead transmitter
          err_nx   = 1'b1;
          ptr_nx   = next_idx(win);
          hold_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_nx = IDLE;
          if (lock_w) begin
            ptr_nx  = win;
            hold_nx = 1'b1;
          end else begin
            ptr_nx  = next_idx(win);
            hold_nx = 1'b0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      win         <= '0;
      cnt         <= '0;
      hold        <= 1'b0;
      gnt         <= '0;
      tx_load     <= 1'b0;
      tx_data     <= 8'h00;
      arb_busy    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      win         <= win_nx;
      cnt         <= cnt_nx;
      hold        <= hold_nx;
      gnt         <= gnt_nx;
      tx_load     <= tx_load_nx;
      tx_data     <= tx_data_nx;
      arb_busy    <= (state_nx != IDLE);
      err_timeout <= err_nx;
    end
  end

endmodule
